// File: rtl/cache_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_pkg
//   Shared types for the instruction/data cache to main-memory arbiter.
//   Block geometry, whole-block request/response structs, arbiter FSM states,
//   one-hot grant encoding and the default watchdog length.
// -----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

   localparam int BLOCK_SIZE         = 2;
   localparam int ADDR_WIDTH         = 32;
   localparam int WORD_WIDTH         = 32;
   localparam int ARB_TIMEOUT_CYCLES = 1024;

   typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

   typedef struct packed {
      logic                  cs;
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      block_t                data;
   } memory_request_t;

   typedef struct packed {
      logic   ack;
      block_t data;
   } memory_response_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RELEASE
   } arb_state_t;

   // One-hot owner: bit0 = instruction cache, bit1 = data cache.
   typedef logic [1:0] grant_t;
   localparam grant_t GRANT_NONE = 2'b00;
   localparam grant_t GRANT_I    = 2'b01;
   localparam grant_t GRANT_D    = 2'b10;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//   One block-transfer port: a request travelling from master to slave and a
//   response travelling back.
//   master : drives req, receives resp (a cache, or the arbiter toward memory)
//   slave  : receives req, drives resp (the arbiter toward a cache, or memory)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;
   import cache_mem_arbiter_pkg::*;

   memory_request_t  req;
   memory_response_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Combinational two-way round-robin pick.
//   i_req[0]      : instruction cache requesting
//   i_req[1]      : data cache requesting
//   i_last_grant  : owner of the previous transfer
//   o_winner      : one-hot winner, GRANT_NONE when nobody requests
// -----------------------------------------------------------------------------
module rr_arbiter2
   import cache_mem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  grant_t     i_last_grant,
   output grant_t     o_winner
);

   always_comb begin
      o_winner = GRANT_NONE;
      case (i_req)
         2'b01:   o_winner = GRANT_I;
         2'b10:   o_winner = GRANT_D;
         // Tie: whoever did not go last wins, giving strict alternation.
         2'b11:   o_winner = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
         default: o_winner = GRANT_NONE;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares the single main-memory block port between the instruction cache and
//   the data cache. The winning request is latched and held stable toward
//   memory until ack; the ack is routed back to the winner only. Round-robin on
//   ties, and a watchdog forces completion if memory never answers.
//
//   clk          : system clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   i_bus        : instruction-cache port (slave side)
//   d_bus        : data-cache port (slave side)
//   mem_bus      : main-memory port (master side)
//   grant        : one-hot current owner, 00 when idle / releasing
//   timeout_err  : sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
)(
   input  logic                clk,
   input  logic                rst_n,
   cache_mem_arbiter_if.slave  i_bus,
   cache_mem_arbiter_if.slave  d_bus,
   cache_mem_arbiter_if.master mem_bus,
   output grant_t              grant,
   output logic                timeout_err
);

   // Watchdog count on the last BUSY cycle allowed before forced completion.
   localparam int                   TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_WIDTH-1:0] TO_LAST     = TO_LAST_INT[CNT_WIDTH-1:0];

   arb_state_t           r_state,       w_state_next;
   grant_t               r_grant,       w_grant_next;
   grant_t               r_last_grant,  w_last_grant_next;
   memory_request_t      r_req,         w_req_next;
   logic [CNT_WIDTH-1:0] r_watchdog,    w_watchdog_next;
   logic                 r_timeout_err, w_timeout_err_next;

   grant_t               w_winner;
   logic                 w_busy;
   logic                 w_mem_ack;
   logic                 w_to_hit;
   logic                 w_timeout_fire;
   logic                 w_win_ack;
   memory_request_t      w_mem_req;
   memory_response_t     w_i_resp;
   memory_response_t     w_d_resp;

   rr_arbiter2 u_rr (
      .i_req        ({d_bus.req.cs, i_bus.req.cs}),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner)
   );

   assign w_busy         = (r_state == ARB_BUSY);
   assign w_mem_ack      = mem_bus.resp.ack;
   assign w_to_hit       = (TIMEOUT_CYCLES != 0) && (r_watchdog == TO_LAST);
   // A real ack in the same cycle as the watchdog limit takes priority.
   assign w_timeout_fire = w_busy && !w_mem_ack && w_to_hit;
   assign w_win_ack      = w_busy && (w_mem_ack || w_timeout_fire);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ARB_IDLE;
         r_grant       <= GRANT_NONE;
         r_last_grant  <= GRANT_I;
         r_req         <= '0;
         r_watchdog    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_grant       <= w_grant_next;
         r_last_grant  <= w_last_grant_next;
         r_req         <= w_req_next;
         r_watchdog    <= w_watchdog_next;
         r_timeout_err <= w_timeout_err_next;
      end
   end

   // ------------------------------------------------------- next state
   always_comb begin
      w_state_next       = r_state;
      w_grant_next       = r_grant;
      w_last_grant_next  = r_last_grant;
      w_req_next         = r_req;
      w_watchdog_next    = r_watchdog;
      w_timeout_err_next = r_timeout_err;

      case (r_state)
         ARB_IDLE: begin
            if (w_winner != GRANT_NONE) begin
               w_state_next      = ARB_BUSY;
               w_grant_next      = w_winner;
               w_last_grant_next = w_winner;
               w_watchdog_next   = '0;
               // Private copy: the requester may change its bus while granted.
               w_req_next        = (w_winner == GRANT_D) ? d_bus.req : i_bus.req;
               w_req_next.cs     = 1'b0;
            end
         end

         ARB_BUSY: begin
            w_watchdog_next = r_watchdog + CNT_WIDTH'(1);
            if (w_mem_ack) begin
               w_state_next = ARB_RELEASE;
               w_grant_next = GRANT_NONE;
            end else if (w_to_hit) begin
               w_state_next       = ARB_RELEASE;
               w_grant_next       = GRANT_NONE;
               w_timeout_err_next = 1'b1;
            end
         end

         ARB_RELEASE: begin
            w_state_next = ARB_IDLE;
         end

         default: begin
            w_state_next = ARB_IDLE;
            w_grant_next = GRANT_NONE;
         end
      endcase
   end

   // ---------------------------------------------------------- outputs
   always_comb begin
      w_mem_req    = r_req;
      w_mem_req.cs = w_busy;
   end

   always_comb begin
      w_i_resp      = '0;
      w_d_resp      = '0;
      // Forced timeout completion returns a zero block so the cache sees
      // deterministic data rather than whatever memory is driving.
      w_i_resp.data = w_timeout_fire ? '0 : mem_bus.resp.data;
      w_d_resp.data = w_timeout_fire ? '0 : mem_bus.resp.data;
      w_i_resp.ack  = w_win_ack && (r_grant == GRANT_I);
      w_d_resp.ack  = w_win_ack && (r_grant == GRANT_D);
   end

   assign mem_bus.req = w_mem_req;
   assign i_bus.resp  = w_i_resp;
   assign d_bus.resp  = w_d_resp;
   assign grant       = r_grant;
   assign timeout_err = r_timeout_err;

endmodule
